bram_operand_collector: RTL

- Parametrised successor to the per-instruction BRAM stall check in the PE operand-fetch path.
- Supports SRC_NUM sources and any set of BRAM-backed namespaces.
- Latches operands that arrive on different cycles, so an instruction issues once every BRAM operand has arrived at least once; it no longer needs all operands valid in the same cycle.
- Adds a registered operand issue stage, downstream backpressure and a stall watchdog. It sits between the instruction decoder and the PE ALU operand registers.

---
 rtl/bram_operand_collector.sv | 118 +++++++++++
 1 files changed

// File: rtl/bram_operand_collector.sv
// bram_operand_collector: collects BRAM-backed source operands across cycles, then issues
// them through a registered stage with downstream backpressure and a stall watchdog.
`default_nettype none

module bram_operand_collector #(
  parameter int SRC_NUM     = 2,
  parameter int NS_BITS     = 3,
  parameter int DATA_WIDTH  = 16,
  parameter logic [(1<<NS_BITS)-1:0] BRAM_NS_MASK = 8'b0000_1011,
  parameter int CNT_WIDTH   = 8,
  parameter int STALL_LIMIT = 200
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               inst_valid,
  input  logic [SRC_NUM*(1<<NS_BITS)-1:0]    src_decoder_out,
  input  logic [(1<<NS_BITS)-1:0]            ns_out_v,
  input  logic [(1<<NS_BITS)*DATA_WIDTH-1:0] ns_out_data,
  input  logic                               issue_ready,
  output logic [SRC_NUM-1:0]                 src_v_bram,
  output logic                               inst_stall_bram,
  output logic                               op_valid,
  output logic [SRC_NUM*DATA_WIDTH-1:0]      op_data,
  output logic [SRC_NUM-1:0]                 op_from_bram,
  output logic                               stall_timeout,
  output logic [CNT_WIDTH-1:0]               stall_cycles
);

  localparam int NS = 1 << NS_BITS;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] LIMIT_CNT = CNT_WIDTH'(STALL_LIMIT);

  logic [SRC_NUM-1:0]            cap;
  logic [SRC_NUM*DATA_WIDTH-1:0] cap_data;
  logic [SRC_NUM-1:0]            req;
  logic [SRC_NUM-1:0]            hit;
  logic [SRC_NUM-1:0]            avail;
  logic [SRC_NUM*DATA_WIDTH-1:0] hdata;
  logic [NS-1:0]                 sel;
  logic [DATA_WIDTH-1:0]         lane_or;
  logic                          all_ok;
  logic                          fire;

  // A multi-hot select ORs the chosen lanes rather than picking one, so no X can leak.
  always_comb begin
    all_ok  = 1'b1;
    sel     = '0;
    lane_or = '0;
    req     = '0;
    hit     = '0;
    avail   = '0;
    hdata   = '0;
    for (int s = 0; s < SRC_NUM; s++) begin
      sel      = src_decoder_out[s*NS +: NS];
      req[s]   = |(sel & BRAM_NS_MASK);
      hit[s]   = |(sel & ns_out_v & BRAM_NS_MASK);
      avail[s] = cap[s] | hit[s];
      if (req[s] && !avail[s]) all_ok = 1'b0;
      lane_or = '0;
      for (int n = 0; n < NS; n++) begin
        if (sel[n]) lane_or = lane_or | ns_out_data[n*DATA_WIDTH +: DATA_WIDTH];
      end
      hdata[s*DATA_WIDTH +: DATA_WIDTH] = lane_or;
    end
  end

  assign fire            = inst_valid & all_ok & issue_ready;
  assign inst_stall_bram = inst_valid & ~fire;
  assign src_v_bram      = req & avail & {SRC_NUM{inst_valid}};

  always_ff @(posedge clk) begin
    if (reset) begin
      cap           <= '0;
      cap_data      <= '0;
      op_valid      <= 1'b0;
      op_data       <= '0;
      op_from_bram  <= '0;
      stall_cycles  <= '0;
      stall_timeout <= 1'b0;
    end else begin
      op_valid <= fire;
      if (fire) begin
        op_from_bram <= req;
        for (int s = 0; s < SRC_NUM; s++) begin
          if (cap[s])
            op_data[s*DATA_WIDTH +: DATA_WIDTH] <= cap_data[s*DATA_WIDTH +: DATA_WIDTH];
          else if (req[s])
            op_data[s*DATA_WIDTH +: DATA_WIDTH] <= hdata[s*DATA_WIDTH +: DATA_WIDTH];
          else
            op_data[s*DATA_WIDTH +: DATA_WIDTH] <= '0;
        end
      end

      // Captures live only while the same instruction is held and waiting.
      if (!inst_valid || fire) begin
        cap <= '0;
      end else begin
        for (int s = 0; s < SRC_NUM; s++) begin
          if (req[s] && hit[s] && !cap[s]) begin
            cap[s]                               <= 1'b1;
            cap_data[s*DATA_WIDTH +: DATA_WIDTH] <= hdata[s*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end

      if (inst_stall_bram) begin
        if (stall_cycles != CNT_MAX) stall_cycles <= stall_cycles + 1'b1;
        stall_timeout <= (stall_cycles >= LIMIT_CNT);
      end else begin
        stall_cycles  <= '0;
        stall_timeout <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
